// File: rtl/muldiv_seq.sv
// Multi-cycle signed/unsigned multiply and divide unit feeding HI/LO.
// One result bit per cycle: shift-add multiply, restoring divide.
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz_out;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_dz_in;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz_out;

  // Operand conditioning at accept and per-cycle multiply/divide step.
  always_comb begin
    w_a_neg   = ~op[0] & A[WIDTH-1];
    w_b_neg   = ~op[0] & B[WIDTH-1];
    w_a_mag   = w_a_neg ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
    w_b_mag   = w_b_neg ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
    w_dz_in   = op[1] && (B == {WIDTH{1'b0}});

    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // The borrow out of the trial subtraction decides the quotient bit.
    w_shift   = {r_rem, r_acc[WIDTH-1]};
    w_diff    = w_shift - {2'b00, r_opnd};
    w_ge      = ~w_diff[WIDTH+1];
    w_rem_nxt = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    w_q_nxt   = {r_acc[WIDTH-2:0], w_ge};
  end

  // Sign correction applied when the result is written back.
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_acc;
    if (r_is_div) begin
      w_lo_fin = r_neg_q ? (~r_acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : r_acc[WIDTH-1:0];
      w_hi_fin = r_neg_r ? (~r_rem[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                         : r_rem[WIDTH-1:0];
    end else begin
      w_lo_fin = w_prod[WIDTH-1:0];
      w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_dz_in ? S_FIN : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_next = S_FIN;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_opnd   <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dz_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= w_dz_in;
            r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_is_div) begin
            r_rem              <= w_rem_nxt;
            r_acc[WIDTH-1:0]   <= w_q_nxt;
          end else begin
            r_acc <= w_mul_nxt;
          end
        end
        S_FIN: begin
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_dz_out <= r_dz;
          if (!r_dz) begin
            r_hi <= w_hi_fin;
            r_lo <= w_lo_fin;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Parametrised multi-cycle multiply/divide unit. It is the successor to the fixed 32-bit `mult` block and feeds the CPU's HI/LO registers. It generalises operand width and adds four modes: signed/unsigned multiply and signed/unsigned divide. It also adds a start/busy/done handshake and divide-by-zero flagging. The control unit stalls on busy and samples HI/LO on done.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; legal range 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
A  input  WIDTH  multiplicand / dividend
B  input  WIDTH  multiplier / divisor
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
start  input  1  request; sampled only in IDLE
HI  output  WIDTH  product upper half / remainder
LO  output  WIDTH  product lower half / quotient
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse
div_zero  output  1  high together with done when a DIV/DIVU had B==0

Behaviour:
- Reset (synchronous, active-high):
  - HI=0, LO=0, busy=0, done=0, div_zero=0; FSM to IDLE; counter=0.
  - Reset overrides everything, including an operation in progress, which is aborted with no done.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 on an edge: latch A, B, op; compute operand magnitudes (signed ops only) and record result signs.
  - Then set busy=1, counter=0, next state CALC.
  - Exception: a DIV/DIVU with B==0 goes straight to FIN with the dz flag set.
- CALC:
  - Exactly one bit per cycle, counter 0..WIDTH-1; on counter==WIDTH-1, next state is FIN.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing the quotient and a WIDTH+1-bit partial remainder.
- FIN:
  - Apply sign correction and write HI/LO.
  - done=1 and busy=0 for this one cycle, then IDLE.
  - On a divide-by-zero: HI/LO keep their previous values, div_zero=1 with done, and div_zero clears with done.
- Latency:
  - Start accepted at edge t; done high in the cycle following edge t+WIDTH+1 (WIDTH+2 edges in total).
  - Divide-by-zero: done in the cycle following edge t+1.
- Output hold: HI/LO change only in FIN and otherwise hold, so they are readable any time after done.
- start while busy: ignored. No queuing and no latch of new operands.
- start asserted in the FIN cycle: ignored. It is accepted only if still high at the next edge, in IDLE.
- Signed MULT: full 2*WIDTH two's-complement product; negate the magnitude product when sign(A)!=sign(B).
- Signed DIV: truncates toward zero.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Overflow case (most-negative / -1): LO = most-negative (wraps), HI = 0, no flag.
- Unsigned ops: no sign handling; the most-negative pattern is a plain large value.
- op and operands are used only as latched at accept; input changes during CALC are ignored.

Test Plan:
1. WIDTH=32, MULTU A=6 B=7, start for 1 cycle → busy high; done after 34 edges; HI=0, LO=42; busy low in the done cycle.
2. MULT A=-3 (0xFFFFFFFD) B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
3. DIV A=-7 B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=100 B=7 → LO=14, HI=2. DIV A=0x80000000 B=-1 → LO=0x80000000, HI=0.
4. Preload HI/LO via MULTU 6*7, then DIVU A=5 B=0 → done after 2 edges with div_zero=1; HI=0, LO=42 unchanged; div_zero low next cycle.
5. Start MULTU 6*7, then assert start with A=9 B=9 at cycle 10 while busy → ignored; result HI=0, LO=42; exactly one done pulse.
6. Start MULT, assert reset at cycle 15 for one cycle → HI=LO=0, busy=0, no done pulse. A new MULTU 3*4 afterwards → LO=12 with normal latency.
7. Re-run scenarios 1 and 3 at WIDTH=8 (MULTU 15*17 → HI=0x00, LO=0xFF; DIV -7/2 → LO=0xFD, HI=0xFF) → done after 10 edges.
